// File: rtl/tl_rx_cpl_tag_scoreboard_if.sv
// Tag-scoreboard bus: TX allocation handshake and RX completion header fields.
interface tl_rx_cpl_tag_scoreboard_if #(
    parameter int unsigned REQUESTER_ID_WIDTH  = 16,
    parameter int unsigned REQUESTER_TAG_WIDTH = 10
);
    logic                           alloc_req;
    logic                           alloc_ready;
    logic [REQUESTER_TAG_WIDTH-1:0] alloc_tag;
    logic                           cpl_valid;
    logic [REQUESTER_ID_WIDTH-1:0]  cpl_req_id;
    logic [REQUESTER_TAG_WIDTH-1:0] cpl_tag;
    logic                           cpl_last;

    modport master (
        output alloc_req,
        input  alloc_ready,
        input  alloc_tag,
        output cpl_valid,
        output cpl_req_id,
        output cpl_tag,
        output cpl_last
    );

    modport slave (
        input  alloc_req,
        output alloc_ready,
        output alloc_tag,
        input  cpl_valid,
        input  cpl_req_id,
        input  cpl_tag,
        input  cpl_last
    );
endinterface

// File: rtl/tl_rx_cpl_tag_scoreboard.sv
// Outstanding non-posted tag scoreboard: lowest-free allocation, completion retire/check, drain FSM.
// Optional per-tag completion timeout enabled by defining TL_RX_CPL_TIMEOUT_EN.
module tl_rx_cpl_tag_scoreboard #(
    parameter int unsigned REQUESTER_ID_WIDTH  = 16,
    parameter int unsigned REQUESTER_TAG_WIDTH = 10,
    parameter int unsigned NUM_TAGS            = 32,
    parameter int unsigned TIMEOUT_WIDTH       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    tl_rx_cpl_tag_scoreboard_if.slave      bus,
    input  logic [REQUESTER_ID_WIDTH-1:0]  own_req_id,
    input  logic                           uc_en,
    output logic                           uc_error,
    output logic [REQUESTER_TAG_WIDTH-1:0] uc_err_tag,
    output logic [8:0]                     free_count,
    input  logic                           drain_req,
    output logic                           drained,
    output logic                           cpl_timeout,
    output logic [REQUESTER_TAG_WIDTH-1:0] timeout_tag
);
    localparam int unsigned IdxW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam logic [8:0] AllFree = 9'(NUM_TAGS);

    typedef enum logic [1:0] {StRun, StDrain, StDrained} state_e;

    state_e              state;
    logic [NUM_TAGS-1:0] busy;
    logic [NUM_TAGS-1:0] busy_d;
    logic [8:0]          free_count_d;
    logic [IdxW-1:0]     free_idx;
    logic [IdxW-1:0]     cpl_idx;
    logic [IdxW-1:0]     exp_idx;
    logic                tag_in_range;
    logic                hit;
    logic                retire;
    logic                alloc_fire;
    logic                uc_fire;
    logic                to_fire;

    // Lowest free tag; the descending scan leaves the smallest index last.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IdxW'(i);
        end
    end

    assign bus.alloc_ready = (state == StRun) && (free_count != 9'd0);
    assign bus.alloc_tag   = (free_count != 9'd0) ? REQUESTER_TAG_WIDTH'(free_idx) : '0;
    assign alloc_fire      = bus.alloc_req && bus.alloc_ready;

    assign cpl_idx      = bus.cpl_tag[IdxW-1:0];
    assign tag_in_range = 32'(bus.cpl_tag) < NUM_TAGS;
    assign hit          = (bus.cpl_req_id == own_req_id) && tag_in_range && busy[cpl_idx];
    assign retire       = bus.cpl_valid && hit && bus.cpl_last;
    assign uc_fire      = bus.cpl_valid && !hit && uc_en;

    // A tag retired this cycle is not re-issued: free_idx comes from the pre-edge bitmap.
    always_comb begin
        busy_d       = busy;
        free_count_d = free_count;
        if (alloc_fire) begin
            busy_d[free_idx] = 1'b1;
            free_count_d     = free_count_d - 9'd1;
        end
        if (retire) begin
            busy_d[cpl_idx] = 1'b0;
            free_count_d    = free_count_d + 9'd1;
        end
        if (to_fire) begin
            busy_d[exp_idx] = 1'b0;
            free_count_d    = free_count_d + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy       <= '0;
            free_count <= AllFree;
            uc_error   <= 1'b0;
            uc_err_tag <= '0;
        end else begin
            busy       <= busy_d;
            free_count <= free_count_d;
            uc_error   <= uc_fire;
            if (uc_fire) uc_err_tag <= bus.cpl_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= StRun;
            drained <= 1'b0;
        end else begin
            unique case (state)
                StRun: begin
                    if (drain_req) state <= StDrain;
                end
                StDrain: begin
                    if (!drain_req) begin
                        state <= StRun;
                    end else if (free_count == AllFree) begin
                        state   <= StDrained;
                        drained <= 1'b1;
                    end
                end
                StDrained: begin
                    if (!drain_req) begin
                        state   <= StRun;
                        drained <= 1'b0;
                    end
                end
                default: begin
                    state   <= StRun;
                    drained <= 1'b0;
                end
            endcase
        end
    end

`ifdef TL_RX_CPL_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] age [NUM_TAGS];
    logic                     exp_found;

    always_comb begin
        exp_found = 1'b0;
        exp_idx   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (busy[i] && (age[i] == '1)) begin
                exp_found = 1'b1;
                exp_idx   = IdxW'(i);
            end
        end
    end

    // A completion retiring the expiring tag wins; the timeout is dropped silently.
    assign to_fire = exp_found && !(retire && (exp_idx == cpl_idx));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAGS; i++) age[i] <= '0;
            cpl_timeout <= 1'b0;
            timeout_tag <= '0;
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (alloc_fire && (free_idx == IdxW'(i))) begin
                    age[i] <= '0;
                end else if (busy[i] && (age[i] != '1)) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
            cpl_timeout <= to_fire;
            if (to_fire) timeout_tag <= REQUESTER_TAG_WIDTH'(exp_idx);
        end
    end
`else
    assign to_fire     = 1'b0;
    assign exp_idx     = '0;
    assign cpl_timeout = 1'b0;
    assign timeout_tag = '0;
`endif
endmodule
